// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs: definitions shared by the core's control unit, the writable
// program memory and the program loader.
//   PM_ADDR_W / PM_DATA_W : program memory geometry (5-bit PC, 16-bit words)
//   PM_STOP_ADDR          : the core's STOP address; a loader never writes it
//   LD_*                  : program_loader state encoding
//   ld_*() helpers        : per-state output decode used by the loader
// -----------------------------------------------------------------------------
package cpu_defs;

  localparam int PM_ADDR_W    = 5;
  localparam int PM_DATA_W    = 16;
  localparam int PM_STOP_ADDR = 31;

  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_COUNT = 3'd1;
  localparam logic [2:0] LD_HI    = 3'd2;
  localparam logic [2:0] LD_LO    = 3'd3;
  localparam logic [2:0] LD_WRITE = 3'd4;
  localparam logic [2:0] LD_CHECK = 3'd5;
  localparam logic [2:0] LD_DONE  = 3'd6;
  localparam logic [2:0] LD_ERROR = 3'd7;

  // States that consume a byte from the source.
  function automatic logic ld_ready(input logic [2:0] s);
    return (s == LD_COUNT) || (s == LD_HI) || (s == LD_LO) || (s == LD_CHECK);
  endfunction

  // States that belong to an active session.
  function automatic logic ld_busy(input logic [2:0] s);
    return ld_ready(s) || (s == LD_WRITE);
  endfunction

  // The core may only run when idle or after a good load; a failed load keeps
  // it parked so it never executes a half-written program.
  function automatic logic ld_hold(input logic [2:0] s);
    return (s != LD_IDLE) && (s != LD_DONE);
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer: assembles a big-endian 16-bit word from two bytes and raises a
// one-cycle word_done strobe the cycle after the low byte lands.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   hi_en, lo_en : load byte_in into the high / low half of word
//   byte_in      : incoming byte
//   word         : assembled word (held until overwritten)
//   word_done    : single-cycle pulse, word is complete and stable
// -----------------------------------------------------------------------------
module byte_packer #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset in the sensitivity list, so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      if (hi_en) word[DATA_W-1 -: 8] <= byte_in;
      if (lo_en) word[7:0]           <= byte_in;
      word_done <= lo_en;
    end
  end

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader: writes a program into the core's writable program memory
// from a byte stream while holding the core in reset.
// Frame: count N (1..MAX_WORDS), N words high byte first, checksum byte
// (XOR of count and all data bytes).
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   start              : one-cycle pulse, begins a session when not busy
//   in_valid/in_data   : byte source; in_ready shows acceptance this cycle
//   pm_we/pm_addr/pm_wdata : program memory write port
//   core_hold          : ORed into the core's reset
//   busy/done/error    : session status (done/error sticky until next start)
//   words_loaded       : words written in the current or last session
// -----------------------------------------------------------------------------
module program_loader
  import cpu_defs::*;
#(
  parameter int ADDR_W    = PM_ADDR_W,
  parameter int DATA_W    = PM_DATA_W,
  parameter int MAX_WORDS = PM_STOP_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  logic [2:0]        state, next_state;
  logic [ADDR_W-1:0] count_n;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] words_next;
  logic              fire;
  logic              launch;
  logic              count_bad;

  // in_ready is registered from the next state, so it always reflects the
  // current state and can qualify the handshake directly.
  assign fire       = in_valid && in_ready;
  assign launch     = start && !ld_busy(state);
  assign count_bad  = (in_data == 8'd0) || (in_data > MAX_N);
  assign words_next = words_loaded + ADDR_W'(1);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERROR: if (start) next_state = LD_COUNT;
      LD_COUNT: if (fire) next_state = count_bad ? LD_ERROR : LD_HI;
      LD_HI:    if (fire) next_state = LD_LO;
      LD_LO:    if (fire) next_state = LD_WRITE;
      LD_WRITE: next_state = (words_next == count_n) ? LD_CHECK : LD_HI;
      LD_CHECK: if (fire) next_state = (in_data == csum) ? LD_DONE : LD_ERROR;
      default:  next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= LD_IDLE;
      count_n      <= '0;
      csum         <= '0;
      words_loaded <= '0;
      pm_addr      <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      in_ready     <= 1'b0;
      core_hold    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= ld_ready(next_state);
      core_hold <= ld_hold(next_state);
      busy      <= ld_busy(next_state);

      if (state == LD_COUNT && fire) count_n <= in_data[ADDR_W-1:0];

      // Accumulator covers count and data bytes, never the checksum itself.
      if (launch)
        csum <= '0;
      else if (fire && (state == LD_COUNT || state == LD_HI || state == LD_LO))
        csum <= csum ^ in_data;

      if (launch)
        words_loaded <= '0;
      else if (state == LD_WRITE)
        words_loaded <= words_next;

      // Address is captured as the word completes so it is stable for the
      // whole write cycle, alongside the packer's word.
      if (state == LD_LO && fire) pm_addr <= words_loaded;

      if (launch) begin
        done  <= 1'b0;
        error <= 1'b0;
      end else begin
        if (state == LD_CHECK && next_state == LD_DONE) done <= 1'b1;
        if (ld_busy(state) && next_state == LD_ERROR)   error <= 1'b1;
      end
    end
  end

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .hi_en     (fire && state == LD_HI),
    .lo_en     (fire && state == LD_LO),
    .byte_in   (in_data),
    .word      (pm_wdata),
    .word_done (pm_we)
  );

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader: directed bench for program_loader. A monitor logs every
// program-memory write; the stimulus is one linear sequence of sessions.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pm_we;
  logic [4:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  words_loaded;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [4:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] frame_words[0:30];
  bit          saw_stop = 1'b0;

  program_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .pm_we        (pm_we),
    .pm_addr      (pm_addr),
    .pm_wdata     (pm_wdata),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pm_we) begin
      wr_addr.push_back(pm_addr);
      wr_data.push_back(pm_wdata);
      if (pm_addr == 5'd31) saw_stop = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 64) begin
      step();
      waited++;
    end
    check("byte_accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Sends the words and checksum of an n-word frame whose count is already sent.
  task automatic send_body(input int n, input bit bad, input bit gaps);
    logic [7:0] cs;
    cs = 8'(n);
    for (int i = 0; i < n; i++) begin
      cs = cs ^ frame_words[i][15:8] ^ frame_words[i][7:0];
      send_byte(frame_words[i][15:8], gaps);
      send_byte(frame_words[i][7:0], gaps);
    end
    if (bad) cs = cs ^ 8'h01;
    send_byte(cs, gaps);
  endtask

  task automatic send_frame(input int n, input bit bad, input bit gaps);
    send_byte(8'(n), gaps);
    send_body(n, bad, gaps);
  endtask

  task automatic check_writes(input int n);
    check("write_count", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check($sformatf("write_addr[%0d]", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("write_data[%0d]", i), 32'(wr_data[i]), 32'(frame_words[i]));
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    int c0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values
    #12;
    check("rst_in_ready",     32'(in_ready),     32'd0);
    check("rst_pm_we",        32'(pm_we),        32'd0);
    check("rst_core_hold",    32'(core_hold),    32'd0);
    check("rst_busy",         32'(busy),         32'd0);
    check("rst_done",         32'(done),         32'd0);
    check("rst_error",        32'(error),        32'd0);
    check("rst_pm_addr",      32'(pm_addr),      32'd0);
    check("rst_pm_wdata",     32'(pm_wdata),     32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Bytes offered in IDLE are not consumed
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) step();
    check("idle_in_ready",  32'(in_ready),  32'd0);
    check("idle_busy",      32'(busy),      32'd0);
    check("idle_core_hold", 32'(core_hold), 32'd0);
    in_valid = 1'b0;

    // Good 2-word frame, source always valid
    frame_words[0] = 16'h9012;
    frame_words[1] = 16'hB901;
    pulse_start();
    c0 = cyc;
    check("start_in_ready",  32'(in_ready),  32'd1);
    check("start_core_hold", 32'(core_hold), 32'd1);
    check("start_busy",      32'(busy),      32'd1);
    send_frame(2, 1'b0, 1'b0);
    check("good_cycles",       32'(cyc - c0),     32'd8);
    check("good_done",         32'(done),         32'd1);
    check("good_error",        32'(error),        32'd0);
    check("good_core_hold",    32'(core_hold),    32'd0);
    check("good_busy",         32'(busy),         32'd0);
    check("good_words_loaded", 32'(words_loaded), 32'd2);
    check_writes(2);

    // Bad checksum (0x39 instead of 0x38)
    pulse_start();
    check("restart_done_cleared", 32'(done), 32'd0);
    send_frame(2, 1'b1, 1'b0);
    check("badcs_error",     32'(error),     32'd1);
    check("badcs_done",      32'(done),      32'd0);
    check("badcs_core_hold", 32'(core_hold), 32'd1);
    check("badcs_in_ready",  32'(in_ready),  32'd0);
    check_writes(2);

    // Illegal count 0x00 from ERROR
    pulse_start();
    check("err_restart_error", 32'(error), 32'd0);
    send_byte(8'h00, 1'b0);
    check("cnt00_error",    32'(error),    32'd1);
    check("cnt00_in_ready", 32'(in_ready), 32'd0);
    check("cnt00_busy",     32'(busy),     32'd0);
    check_writes(0);

    // Bytes offered in ERROR are not consumed
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (3) step();
    check("errst_in_ready",  32'(in_ready),  32'd0);
    check("errst_error",     32'(error),     32'd1);
    check("errst_core_hold", 32'(core_hold), 32'd1);
    in_valid = 1'b0;

    // Illegal count 0x20
    pulse_start();
    send_byte(8'h20, 1'b0);
    check("cnt20_error",    32'(error),    32'd1);
    check("cnt20_in_ready", 32'(in_ready), 32'd0);
    check_writes(0);

    // Maximum 31-word frame with a stalling source, started from ERROR
    for (int i = 0; i < 31; i++)
      frame_words[i] = {8'(i * 7 + 8'h30), 8'(i ^ 8'hC3)};
    pulse_start();
    check("max_error_cleared", 32'(error), 32'd0);
    send_frame(31, 1'b0, 1'b1);
    check("max_done",         32'(done),         32'd1);
    check("max_core_hold",    32'(core_hold),    32'd0);
    check("max_words_loaded", 32'(words_loaded), 32'd31);
    check("max_no_stop_addr", 32'(saw_stop),     32'd0);
    check_writes(31);

    // Asynchronous reset during word 3 of a 5-word frame
    pulse_start();
    send_byte(8'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_byte(frame_words[i][15:8], 1'b0);
      send_byte(frame_words[i][7:0], 1'b0);
    end
    send_byte(frame_words[2][15:8], 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready",     32'(in_ready),     32'd0);
    check("arst_core_hold",    32'(core_hold),    32'd0);
    check("arst_busy",         32'(busy),         32'd0);
    check("arst_done",         32'(done),         32'd0);
    check("arst_pm_wdata",     32'(pm_wdata),     32'd0);
    check("arst_pm_addr",      32'(pm_addr),      32'd0);
    check("arst_words_loaded", 32'(words_loaded), 32'd0);
    check_writes(2);
    step();
    reset = 1'b0;
    frame_words[0] = 16'h1234;
    frame_words[1] = 16'h5678;
    frame_words[2] = 16'h9ABC;
    pulse_start();
    send_frame(3, 1'b0, 1'b0);
    check("post_rst_done",  32'(done),         32'd1);
    check("post_rst_words", 32'(words_loaded), 32'd3);
    check_writes(3);

    // start pulsed during HI is ignored
    frame_words[0] = 16'hA5A5;
    frame_words[1] = 16'h0F0F;
    pulse_start();
    send_byte(8'd2, 1'b0);
    pulse_start();
    check("hi_start_in_ready", 32'(in_ready),     32'd1);
    check("hi_start_busy",     32'(busy),         32'd1);
    check("hi_start_words",    32'(words_loaded), 32'd0);
    send_body(2, 1'b0, 1'b0);
    check("hi_start_done",  32'(done),  32'd1);
    check("hi_start_error", 32'(error), 32'd0);
    check_writes(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes instruction words into the core's writable program memory from a byte stream (UART RX or debug port) while holding the core in reset, so the control unit can fetch a new program without re-synthesis. It sits between the byte source and the program memory write port. Its `core_hold` output is ORed into the core's `reset`. The control unit is the reader of program memory; this block is its writer.

## Interface
Parameters:
- `ADDR_W`, 5: program memory address width; matches the 5-bit `PC`.
- `DATA_W`, 16: instruction width.
- `MAX_WORDS`, 31: largest accepted program. Address 31 is the core's STOP address and is never written.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a load session.
- `in_valid`  in  1  byte source has data.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `pm_we`  out  1  program memory write strobe.
- `pm_addr`  out  ADDR_W  write address.
- `pm_wdata`  out  DATA_W  write data.
- `core_hold`  out  1  holds the core in reset.
- `busy`  out  1  session in progress.
- `done`  out  1  last session succeeded; sticky.
- `error`  out  1  last session failed; sticky.
- `words_loaded`  out  ADDR_W  count of words written in the current or last session.

## Operation
- **Byte transfer:** occurs on a rising edge where `in_valid && in_ready`.
- **Frame format:** count byte N (1..MAX_WORDS), then N words as 2 bytes each (high byte first), then checksum byte. Checksum = XOR of the count byte and all data bytes.
- **States:** IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR + `start` -> COUNT. On entry: clear `words_loaded`, checksum accumulator, `done` and `error`.
  - COUNT: accept byte. If N == 0 or N > MAX_WORDS -> ERROR. Else latch N -> HI.
  - HI: accept byte into `pm_wdata[15:8]` -> LO.
  - LO: accept byte into `pm_wdata[7:0]` -> WRITE.
  - WRITE: `pm_we` = 1 for exactly this cycle with `pm_addr` = `words_loaded`. Then increment `words_loaded`. If the new count equals N -> CHECK, else -> HI.
  - CHECK: accept byte. If it equals the accumulator -> DONE (`done` = 1), else -> ERROR (`error` = 1).
- **Checksum accumulator:** XORs every accepted byte except the checksum byte.
- **`in_ready`:** 1 only in COUNT, HI, LO, CHECK. 0 in IDLE, WRITE, DONE, ERROR.
- **`core_hold`:** 1 in every state except IDLE and DONE. ERROR keeps the core held until a successful session or `reset`.
- **`busy`:** 1 in COUNT, HI, LO, WRITE, CHECK.
- **`start` while busy:** ignored.
- **Bytes while not ready:** offered bytes in IDLE/DONE/ERROR are not consumed and have no effect.
- **`reset`:** asynchronous abort from any state to IDLE. Already-written memory words are left as they are.

## Timing
- **Reset values:**
  - state = IDLE.
  - `in_ready` = `pm_we` = `core_hold` = `busy` = `done` = `error` = 0.
  - `pm_addr` = 0, `pm_wdata` = 0, `words_loaded` = 0.
- **`start` latency:** `start` sampled at edge k -> COUNT, `core_hold` = 1 and `in_ready` = 1 in cycle k+1.
- **Write latency:** LO byte accepted at edge k -> `pm_we` high in cycle k+1 only. Next byte can be accepted at edge k+2.
- **Minimum session length:** 3N + 2 cycles from `start` to DONE with `in_valid` held high. Each word costs 3 cycles (HI, LO, WRITE).
- **Outputs:** all registered. `pm_addr` and `pm_wdata` are stable during the `pm_we` cycle.
- **Release:** `core_hold` falls in the cycle after the checksum byte is accepted with a match. The core then resets to PC = 0 on the following edge.
- **Source stalls:** `in_valid` low simply stalls the state machine. There is no timeout.

## Structure
- **Shared package/header (`cpu_defs`):**
  - state encoding localparams.
  - `PM_ADDR_W`, `PM_DATA_W`, `PM_STOP_ADDR` (31); also used by control_unit and program_memory.
- **Sub-module:** one natural sub-module, `byte_packer`. It collects two bytes into a word and signals word complete. The checksum XOR stays inline in the FSM.
- **Program memory:** the writable variant gains `we`/`waddr`/`wdata` ports. This block contains no memory.

## Test plan
- **Good 2-word frame:** `start`, then bytes 0x02, 0x90, 0x12, 0xB9, 0x01, 0x38 with `in_valid` held -> `pm_we` at addr 0 data 0x9012, then addr 1 data 0xB901; `done` = 1, `core_hold` falls, `words_loaded` = 2, 8 cycles `start`->DONE.
- **Bad checksum:** same frame with last byte 0x39 -> both words written, `error` = 1, `done` = 0, `core_hold` stays 1.
- **Illegal count:** count byte 0x00, and separately 0x20 -> ERROR on the next edge, no `pm_we`, `in_ready` = 0.
- **Stalling source:** max frame of 31 words with random `in_valid` gaps -> 31 writes at addr 0..30, never addr 31, `done` = 1.
- **Reset mid-session:** assert `reset` asynchronously during word 3 -> outputs at reset values immediately; a subsequent `start` and good frame loads correctly.
- **Protocol edges:** `start` pulsed during HI is ignored; bytes offered in IDLE are not accepted; a new `start` from ERROR clears `error` and a good frame reaches DONE.
